// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state type, key map and key-function codes for keypad entry
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} scan_state_e;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_BACK  = 4'hB;
   localparam logic [3:0] KEY_ENTER = 4'hC;
   localparam int unsigned DEC_MAX  = 1023;

   // Indexed by {row, col}; bottom row carries E 0 F D.
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   function automatic logic single_low(input logic [3:0] col);
      return (col == 4'b1110) || (col == 4'b1101) ||
             (col == 4'b1011) || (col == 4'b0111);
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] col);
      case (col)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - row scan, input synchronisers, debounce FSM and key decode
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_in,
   input  logic       dec_mode,
   input  logic       enter_btn,
   output logic [3:0] row_out,
   output logic       dec_sync,
   output logic       enter_sync,
   output logic [3:0] key_code,
   output logic       key_pulse
);

   localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

   logic [3:0]    col_s1_q, col_s2_q;
   logic [1:0]    dec_s_q, ent_s_q;
   logic [DW-1:0] div_q;
   logic          tick;

   scan_state_e   state_q;
   logic [1:0]    row_q;
   logic [3:0]    row_out_q;
   logic [3:0]    pat_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    code_q;
   logic          pulse_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_s1_q <= 4'hF;
         col_s2_q <= 4'hF;
         dec_s_q  <= 2'b00;
         ent_s_q  <= 2'b00;
      end else begin
         col_s1_q <= col_in;
         col_s2_q <= col_s1_q;
         dec_s_q  <= {dec_s_q[0], dec_mode};
         ent_s_q  <= {ent_s_q[0], enter_btn};
      end
   end

   assign tick = (div_q == DIV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) div_q <= '0;
      else     div_q <= tick ? '0 : div_q + 1'b1;
   end

   // The press counter doubles as the release counter; both start from a known value on entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= SCAN;
         row_q     <= 2'd0;
         row_out_q <= 4'b1111;
         pat_q     <= 4'hF;
         cnt_q     <= '0;
         code_q    <= 4'h0;
         pulse_q   <= 1'b0;
      end else begin
         pulse_q   <= 1'b0;
         row_out_q <= ~(4'b0001 << row_q);
         if (tick) begin
            unique case (state_q)
               SCAN: begin
                  if (single_low(col_s2_q)) begin
                     pat_q   <= col_s2_q;
                     cnt_q   <= CW'(1);
                     state_q <= DEBOUNCE;
                  end else begin
                     row_q <= row_q + 2'd1;
                  end
               end
               DEBOUNCE: begin
                  if (col_s2_q != pat_q) begin
                     state_q <= SCAN;
                     row_q   <= row_q + 2'd1;
                  end else if (cnt_q >= CNT_LAST) begin
                     code_q  <= KEY_MAP[{row_q, low_index(pat_q)}];
                     pulse_q <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= RELEASE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               RELEASE: begin
                  if (col_s2_q != 4'hF) begin
                     cnt_q <= '0;
                  end else if (cnt_q >= CNT_LAST) begin
                     cnt_q   <= '0;
                     state_q <= SCAN;
                     row_q   <= row_q + 2'd1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: state_q <= SCAN;
            endcase
         end
      end
   end

   assign row_out    = row_out_q;
   assign dec_sync   = dec_s_q[1];
   assign enter_sync = ent_s_q[1];
   assign key_code   = code_q;
   assign key_pulse  = pulse_q;

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad number entry with commit handshake; KEYPAD_ECHO_EN adds the echo port
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] row_out,
   input  logic [3:0] col_in,
   input  logic       dec_mode,
   input  logic       enter_btn,
   input  logic       value_ack,
   output logic [9:0] value_out,
   output logic       value_valid,
   output logic [3:0] key_code,
`ifdef KEYPAD_ECHO_EN
   output logic [9:0] echo,
`endif
   output logic       key_pulse
);

   logic        dec_sync, enter_sync;
   logic [9:0]  entry_q, entry_d;
   logic [9:0]  value_q, value_d;
   logic        valid_q, valid_d;
   logic        dec_prev_q, enter_prev_q;
   logic [13:0] dec_sum;
   logic        commit;

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_scanner (
      .clk        (clk),
      .rst        (rst),
      .col_in     (col_in),
      .dec_mode   (dec_mode),
      .enter_btn  (enter_btn),
      .row_out    (row_out),
      .dec_sync   (dec_sync),
      .enter_sync (enter_sync),
      .key_code   (key_code),
      .key_pulse  (key_pulse)
   );

   // Widened so an overflowing digit can be detected before truncation.
   assign dec_sum = {4'd0, entry_q} * 14'd10 + {10'd0, key_code};
   assign commit  = (enter_sync & ~enter_prev_q) |
                    (key_pulse & dec_sync & (key_code == KEY_ENTER));

   always_comb begin
      entry_d = entry_q;
      value_d = value_q;
      valid_d = valid_q;
      if (key_pulse) begin
         if (!dec_sync) begin
            entry_d = {entry_q[5:0], key_code};
         end else if (key_code <= 4'd9) begin
            if (dec_sum <= 14'(DEC_MAX)) entry_d = dec_sum[9:0];
         end else if (key_code == KEY_CLEAR) begin
            entry_d = '0;
         end else if (key_code == KEY_BACK) begin
            entry_d = entry_q / 10'd10;
         end
      end
      if (dec_sync != dec_prev_q) entry_d = '0;
      if (value_ack) valid_d = 1'b0;
      // A commit while a value is pending is dropped unless the consumer acks in the same cycle.
      if (commit && (!valid_q || value_ack)) begin
         value_d = entry_q;
         valid_d = 1'b1;
         entry_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q      <= '0;
         value_q      <= '0;
         valid_q      <= 1'b0;
         dec_prev_q   <= 1'b0;
         enter_prev_q <= 1'b0;
      end else begin
         entry_q      <= entry_d;
         value_q      <= value_d;
         valid_q      <= valid_d;
         dec_prev_q   <= dec_sync;
         enter_prev_q <= enter_sync;
      end
   end

   assign value_out   = value_q;
   assign value_valid = valid_q;

`ifdef KEYPAD_ECHO_EN
   assign echo = entry_q;
`endif

endmodule
